ps_loop_ctrl: RTL

Hardware zero-overhead loop controller for the program sequencer. It holds a stack of nested DO-UNTIL loop contexts, each with a start address, end address and iteration count. It compares the sequencer's fetch address against the top-of-stack end address. On a match it either requests a fetch redirect back to the loop start or pops the finished context. The sequencer muxes lp_ps_add into its fetch-address register whenever lp_ps_jmp is high.

---
 rtl/ps_loop_ctrl.sv | 100 ++++++++++
 1 files changed

// File: rtl/ps_loop_ctrl.sv
// ps_loop_ctrl: zero-overhead DO-UNTIL loop stack with end-address compare and fetch redirect
module ps_loop_ctrl #(
  parameter int LP_DEPTH = 4,
  parameter int AW       = 16,
  parameter int CW       = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ps_lp_push,
  input  logic [AW-1:0] ps_lp_strt,
  input  logic [AW-1:0] ps_lp_end,
  input  logic [CW-1:0] ps_lp_cnt,
  input  logic          ps_lp_pop,
  input  logic [AW-1:0] ps_lp_faddr,
  input  logic          ps_lp_stall,
  input  logic          ps_lp_clr,
  output logic          lp_ps_jmp,
  output logic [AW-1:0] lp_ps_add,
  output logic          lp_ps_actv,
  output logic [CW-1:0] lp_ps_cntr,
  output logic          lp_ps_done,
  output logic          lp_ps_empty,
  output logic          lp_ps_full,
  output logic          lp_ps_ovf
);
  localparam int IW = $clog2(LP_DEPTH);
  localparam int PW = IW + 1;
  typedef enum logic [1:0] {LP_IDLE = 2'd0, LP_RUN = 2'd1, LP_SHDW = 2'd2} st_t;
  st_t           r_state, w_state_nxt;
  logic [AW-1:0] r_strt [LP_DEPTH];
  logic [AW-1:0] r_end  [LP_DEPTH];
  logic [CW-1:0] r_cnt  [LP_DEPTH];
  logic [PW-1:0] r_ptr, w_ptr_pop, w_ptr_nxt;
  logic [IW-1:0] w_top, w_wr;
  logic          r_jmp, r_done, r_ovf;
  logic [AW-1:0] r_add, w_add_nxt;
  logic          w_nempty, w_cmp_en, w_match, w_mdec, w_mpop, w_pop;
  logic          w_zpush, w_cpush, w_push, w_ovf_set, w_jmp_nxt;
  assign w_nempty  = r_ptr != '0;
  assign w_top     = IW'(r_ptr - PW'(1));
  assign w_match   = w_cmp_en && w_nempty && !ps_lp_stall && ps_lp_faddr == r_end[w_top];
  assign w_mdec    = w_match && r_cnt[w_top] > CW'(1);
  assign w_mpop    = w_match && r_cnt[w_top] == CW'(1);
  assign w_pop     = w_nempty && (w_mpop || ps_lp_pop);
  assign w_ptr_pop = w_pop ? r_ptr - PW'(1) : r_ptr;
  assign w_zpush   = ps_lp_push && ps_lp_cnt == '0;
  assign w_cpush   = ps_lp_push && ps_lp_cnt != '0;
  assign w_push    = w_cpush && w_ptr_pop != PW'(LP_DEPTH);
  assign w_ovf_set = w_cpush && w_ptr_pop == PW'(LP_DEPTH);
  assign w_ptr_nxt = w_push ? w_ptr_pop + PW'(1) : w_ptr_pop;
  assign w_wr      = IW'(w_ptr_pop);
  assign w_jmp_nxt = w_mdec || w_zpush;
  assign w_add_nxt = w_mdec ? r_strt[w_top] : w_zpush ? ps_lp_end + AW'(1) : '0;
  // loop context storage: decrement the matched top, then write a pushed context over the post-pop slot
  always_ff @(posedge clk) begin
    if (w_mdec) r_cnt[w_top] <= r_cnt[w_top] - CW'(1);
    if (w_push) begin
      r_strt[w_wr] <= ps_lp_strt;
      r_end[w_wr]  <= ps_lp_end;
      r_cnt[w_wr]  <= ps_lp_cnt;
    end
  end
  // stack pointer, registered redirect/done pulses and sticky overflow
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ptr  <= '0;
      r_jmp  <= 1'b0;
      r_add  <= '0;
      r_done <= 1'b0;
      r_ovf  <= 1'b0;
    end else begin
      r_ptr  <= w_ptr_nxt;
      r_jmp  <= w_jmp_nxt;
      r_add  <= w_add_nxt;
      r_done <= w_mpop;
      r_ovf  <= w_ovf_set || (r_ovf && !ps_lp_clr);
    end
  end
  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst) r_state <= LP_IDLE;
    else r_state <= w_state_nxt;
  end
  // next state: idle whenever the stack ends up empty, shadow for the cycle a redirect is presented
  always_comb begin
    w_state_nxt = (w_ptr_nxt == '0) ? LP_IDLE : w_jmp_nxt ? LP_SHDW : LP_RUN;
  end
  // end-address compare is live only in RUN
  always_comb begin
    w_cmp_en = r_state == LP_RUN;
  end
  assign lp_ps_jmp   = r_jmp;
  assign lp_ps_add   = r_add;
  assign lp_ps_done  = r_done;
  assign lp_ps_ovf   = r_ovf;
  assign lp_ps_actv  = w_nempty;
  assign lp_ps_empty = !w_nempty;
  assign lp_ps_full  = r_ptr == PW'(LP_DEPTH);
  assign lp_ps_cntr  = w_nempty ? r_cnt[w_top] : '0;
endmodule
